lfsr_ctrl: RTL and testbench



---
 rtl/lfsr_ctrl_pkg.sv | 20 ++
 rtl/lfsr_ctrl_sync.sv | 22 ++
 rtl/lfsr_ctrl.sv | 140 ++++++++++++++
 tb/tb_lfsr_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared opcodes, FSM state type and widths for the LFSR command sequencer.
package lfsr_ctrl_pkg;

    localparam int RATE_W = 8;

    localparam logic [3:0] OP_CLR_ERR   = 4'h0;
    localparam logic [3:0] OP_LOAD_TAPS = 4'h1;
    localparam logic [3:0] OP_LOAD_SEED = 4'h2;
    localparam logic [3:0] OP_SET_RATE  = 4'h3;
    localparam logic [3:0] OP_STEP_ONCE = 4'h4;
    localparam logic [3:0] OP_RUN       = 4'h5;
    localparam logic [3:0] OP_HALT      = 4'h6;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        APPLY
    } state_t;

endpackage

// File: rtl/lfsr_ctrl_sync.sv
// Brings the asynchronous command strobe into the clk domain and flags each rising edge.
module lfsr_ctrl_sync (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic accept
);

    // Bits [1:0] are the synchroniser; bit [2] remembers the previous synchronised level.
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], strobe};
        end
    end

    assign accept = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/lfsr_ctrl.sv
// Nibble-serial command sequencer: holds LFSR taps/seed and generates load and step pulses.
module lfsr_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int           W            = 16,
    parameter int           PRESCALE     = 1,
    parameter logic [W-1:0] DEFAULT_TAPS = 16'hB400,
    parameter logic [W-1:0] DEFAULT_SEED = 16'h0001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_strobe,
    input  logic [3:0]   cmd_data,
    output logic [W-1:0] lfsr_taps,
    output logic [W-1:0] lfsr_seed,
    output logic         lfsr_load,
    output logic         lfsr_step,
    output logic         running,
    output logic         busy,
    output logic         error
);

    localparam int NIBBLES = W / 4;
    localparam int CNT_W   = $clog2(NIBBLES + 1);
    localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic              accept;
    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [W-1:0]      collect_q;
    logic [CNT_W-1:0]  remain_q;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] rate_cnt_q;
    logic [PRE_W-1:0]  presc_q;

    logic idle_accept, in_apply, do_taps, do_seed, do_rate, set_err;
    logic step_once, start_run, tick, div_fire, div_restart;

    lfsr_ctrl_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .strobe (cmd_strobe),
        .accept (accept)
    );

    assign busy = (state_q != IDLE);

    // Zero masks/seeds would lock the LFSR, so APPLY rejects them and raises error instead.
    always_comb begin
        idle_accept = accept && (state_q == IDLE);
        in_apply    = (state_q == APPLY);
        do_taps     = in_apply && (op_q == OP_LOAD_TAPS) && (collect_q != '0);
        do_seed     = in_apply && (op_q == OP_LOAD_SEED) && (collect_q != '0);
        do_rate     = in_apply && (op_q == OP_SET_RATE);
        set_err     = (idle_accept && (cmd_data > OP_HALT)) ||
                      (in_apply && ((op_q == OP_LOAD_TAPS) || (op_q == OP_LOAD_SEED)) &&
                       (collect_q == '0));
        step_once   = idle_accept && (cmd_data == OP_STEP_ONCE);
        start_run   = idle_accept && (cmd_data == OP_RUN);
        tick        = (presc_q == PRE_W'(PRESCALE - 1));
        div_fire    = running && tick && (rate_cnt_q == rate_q);
        div_restart = !running || start_run || do_seed || do_rate;

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && ((cmd_data == OP_LOAD_TAPS) || (cmd_data == OP_LOAD_SEED) ||
                               (cmd_data == OP_SET_RATE))) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept && (remain_q == CNT_W'(1))) begin
                    state_d = APPLY;
                end
            end
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_CLR_ERR;
            collect_q  <= '0;
            remain_q   <= '0;
            rate_q     <= '0;
            rate_cnt_q <= '0;
            presc_q    <= '0;
            lfsr_taps  <= DEFAULT_TAPS;
            lfsr_seed  <= DEFAULT_SEED;
            lfsr_load  <= 1'b0;
            lfsr_step  <= 1'b0;
            running    <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_load <= do_seed;
            lfsr_step <= (div_fire || step_once) && !do_seed;

            if (idle_accept) begin
                op_q      <= cmd_data;
                collect_q <= '0;
                remain_q  <= (cmd_data == OP_SET_RATE) ? CNT_W'(2) : CNT_W'(NIBBLES);
            end else if (accept && (state_q == COLLECT)) begin
                collect_q <= {collect_q[W-5:0], cmd_data};
                remain_q  <= remain_q - 1'b1;
            end

            if (do_taps) lfsr_taps <= collect_q;
            if (do_seed) lfsr_seed <= collect_q;
            if (do_rate) rate_q    <= collect_q[RATE_W-1:0];

            if (set_err) begin
                error <= 1'b1;
            end else if (idle_accept && (cmd_data == OP_CLR_ERR)) begin
                error <= 1'b0;
            end

            if (start_run) begin
                running <= 1'b1;
            end else if (idle_accept && (cmd_data == OP_HALT)) begin
                running <= 1'b0;
            end

            // Prescaler ticks feed the rate counter; both sit at zero whenever stepping is idle.
            if (div_restart) begin
                presc_q    <= '0;
                rate_cnt_q <= '0;
            end else if (tick) begin
                presc_q    <= '0;
                rate_cnt_q <= (rate_cnt_q == rate_q) ? '0 : rate_cnt_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed plus randomized bench for lfsr_ctrl, checked against a command-level model.
module tb_lfsr_ctrl;

    localparam int W        = 16;
    localparam int PRESCALE = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_strobe;
    logic [3:0]   cmd_data;
    logic [W-1:0] lfsr_taps;
    logic [W-1:0] lfsr_seed;
    logic         lfsr_load;
    logic         lfsr_step;
    logic         running;
    logic         busy;
    logic         error;

    lfsr_ctrl #(
        .W            (W),
        .PRESCALE     (PRESCALE),
        .DEFAULT_TAPS (16'hB400),
        .DEFAULT_SEED (16'h0001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_strobe (cmd_strobe),
        .cmd_data   (cmd_data),
        .lfsr_taps  (lfsr_taps),
        .lfsr_seed  (lfsr_seed),
        .lfsr_load  (lfsr_load),
        .lfsr_step  (lfsr_step),
        .running    (running),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log: every load/step seen, tagged with the cycle it was visible in.
    int load_cnt = 0;
    int step_q[$];
    always @(negedge clk) begin
        if (lfsr_load === 1'b1) load_cnt++;
        if (lfsr_step === 1'b1) step_q.push_back(cyc);
    end

    int errors = 0;
    int checks = 0;

    logic [15:0] m_taps, m_seed;
    bit          m_err, m_run;
    int          m_rate;

    int   rise_cyc, run_cyc, halt_cyc, base_load, base_step, exp_n, exp_load, sel, period;
    logic pre_busy;
    logic [15:0] val;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/taps"},    32'(lfsr_taps), 32'(m_taps));
        checkOutput({tag, "/seed"},    32'(lfsr_seed), 32'(m_seed));
        checkOutput({tag, "/running"}, 32'(running),   32'(m_run));
        checkOutput({tag, "/busy"},    32'(busy),      0);
        checkOutput({tag, "/error"},   32'(error),     32'(m_err));
    endtask

    task automatic doReset();
        cmd_strobe = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        m_taps = 16'hB400;
        m_seed = 16'h0001;
        m_err  = 1'b0;
        m_run  = 1'b0;
        m_rate = 0;
    endtask

    // Returns at the first cycle where the effect of this nibble's accept is visible.
    task automatic applyStimulus(input logic [3:0] n);
        if (cmd_strobe) begin
            cmd_strobe = 1'b0;
            repeat ($urandom_range(3, 6)) @(negedge clk);
        end
        cmd_data   = n;
        cmd_strobe = 1'b1;
        rise_cyc   = cyc;
        repeat (2) @(negedge clk);
        pre_busy = busy;
        @(negedge clk);
    endtask

    // Sends opcode plus payload MS nibble first; returns in the cycle after APPLY.
    task automatic sendCmd(input logic [3:0] op, input logic [15:0] value, input int nnib);
        applyStimulus(op);
        checkOutput("cmd/busy_before_accept", 32'(pre_busy), 0);
        checkOutput("cmd/busy_after_op", 32'(busy), 1);
        for (int i = nnib - 1; i >= 0; i--) begin
            applyStimulus(value[4*i +: 4]);
            checkOutput("cmd/busy_payload", 32'(busy), 1);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout cycles=%0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset      = 1'b1;
        cmd_strobe = 1'b0;
        cmd_data   = 4'h0;
        doReset();
        for (int i = 0; i < 20; i++) begin
            checkAll("reset");
            checkOutput("reset/load", 32'(lfsr_load), 0);
            checkOutput("reset/step", 32'(lfsr_step), 0);
            @(negedge clk);
        end

        base_load = load_cnt;
        base_step = step_q.size();
        sendCmd(4'h1, 16'hD008, 4);
        m_taps = 16'hD008;
        checkAll("taps");
        #1;
        checkOutput("taps/no_load", load_cnt - base_load, 0);
        checkOutput("taps/no_step", step_q.size() - base_step, 0);

        base_load = load_cnt;
        sendCmd(4'h2, 16'hACE1, 4);
        m_seed = 16'hACE1;
        checkOutput("seed/load_pulse", 32'(lfsr_load), 1);
        checkAll("seed");
        @(negedge clk);
        checkOutput("seed/load_end", 32'(lfsr_load), 0);
        #1;
        checkOutput("seed/load_count", load_cnt - base_load, 1);

        base_load = load_cnt;
        sendCmd(4'h2, 16'h0000, 4);
        m_err = 1'b1;
        checkAll("zero_seed");
        #1;
        checkOutput("zero_seed/no_load", load_cnt - base_load, 0);
        applyStimulus(4'h0);
        m_err = 1'b0;
        checkAll("clr_err");

        sendCmd(4'h3, 16'h0003, 2);
        m_rate = 3;
        step_q.delete();
        applyStimulus(4'h5);
        m_run   = 1'b1;
        run_cyc = cyc;
        checkAll("run");
        repeat (21) @(negedge clk);
        applyStimulus(4'h6);
        m_run    = 1'b0;
        halt_cyc = cyc;
        checkAll("halt");
        repeat (20) @(negedge clk);
        #1;
        period = (m_rate + 1) * PRESCALE;
        exp_n  = 0;
        for (int t = run_cyc + period; t <= halt_cyc; t += period) begin
            if (exp_n < step_q.size()) checkOutput("run/step_time", step_q[exp_n], t);
            exp_n++;
        end
        checkOutput("run/step_count", step_q.size(), exp_n);

        sendCmd(4'h3, 16'h0000, 2);
        m_rate = 0;
        applyStimulus(4'h5);
        m_run = 1'b1;
        repeat (3) @(negedge clk);
        sendCmd(4'h2, 16'h1234, 4);
        m_seed = 16'h1234;
        checkOutput("load_vs_step/load", 32'(lfsr_load), 1);
        checkOutput("load_vs_step/step", 32'(lfsr_step), 0);
        @(negedge clk);
        checkOutput("load_vs_step/load_end", 32'(lfsr_load), 0);
        checkOutput("load_vs_step/step_next", 32'(lfsr_step), 1);
        checkAll("load_vs_step");
        applyStimulus(4'h6);
        m_run = 1'b0;
        checkAll("halt2");

        applyStimulus(4'h1);
        applyStimulus(4'hA);
        doReset();
        checkAll("reset_mid_cmd");
        step_q.delete();
        applyStimulus(4'h4);
        checkOutput("step_once/pulse", 32'(lfsr_step), 1);
        checkAll("step_once");
        repeat (10) @(negedge clk);
        #1;
        checkOutput("step_once/count", step_q.size(), 1);

        applyStimulus(4'h9);
        m_err = 1'b1;
        checkAll("bad_op");
        checkOutput("bad_op/load", 32'(lfsr_load), 0);
        checkOutput("bad_op/step", 32'(lfsr_step), 0);

        for (int k = 0; k < 8; k++) begin
            sel = $urandom_range(0, 3);
            val = 16'($urandom);
            if ($urandom_range(0, 4) == 0) val = 16'h0000;
            base_load = load_cnt;
            exp_load  = 0;
            case (sel)
                0: begin
                    sendCmd(4'h1, val, 4);
                    if (val == 16'h0000) m_err = 1'b1;
                    else m_taps = val;
                end
                1: begin
                    sendCmd(4'h2, val, 4);
                    if (val == 16'h0000) m_err = 1'b1;
                    else begin
                        m_seed   = val;
                        exp_load = 1;
                    end
                end
                2: begin
                    applyStimulus(4'($urandom_range(7, 15)));
                    m_err = 1'b1;
                end
                default: begin
                    applyStimulus(4'h0);
                    m_err = 1'b0;
                end
            endcase
            checkAll($sformatf("rnd%0d", k));
            @(negedge clk);
            #1;
            checkOutput($sformatf("rnd%0d/load_count", k), load_cnt - base_load, exp_load);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
